// File: rtl/alu.sv
// 32-bit single-cycle ALU with a registered result; the operation is picked by ALUop.
// The result register is cleared asynchronously while rst_n is low.
`timescale 1ns/1ps
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [15:0] imm,
  input  logic [4:0]  sh,
  input  logic [4:0]  ALUop,
  output logic [31:0] result
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
    OP_XOR  = 5'd4,  OP_NOR  = 5'd5,  OP_SLT  = 5'd6,  OP_SLTU = 5'd7,
    OP_SLL  = 5'd8,  OP_SRL  = 5'd9,  OP_SRA  = 5'd10, OP_SLLV = 5'd11,
    OP_SRLV = 5'd12, OP_SRAV = 5'd13, OP_ADDI = 5'd14, OP_ANDI = 5'd15,
    OP_ORI  = 5'd16, OP_XORI = 5'd17, OP_SLTI = 5'd18, OP_SLTIU = 5'd19,
    OP_LUI  = 5'd20
  } op_e;

  logic [31:0] result_d, result_q;
  logic [31:0] imm_sx, imm_zx;
  logic [4:0]  vsh;

  assign imm_sx = {{16{imm[15]}}, imm};
  assign imm_zx = {16'h0000, imm};
  // Variable shifts honour only the low five bits of in1.
  assign vsh    = in1[4:0];

  always_comb begin
    result_d = 32'h0;
    case (ALUop)
      OP_ADD:   result_d = in1 + in2;
      OP_SUB:   result_d = in1 - in2;
      OP_AND:   result_d = in1 & in2;
      OP_OR:    result_d = in1 | in2;
      OP_XOR:   result_d = in1 ^ in2;
      OP_NOR:   result_d = ~(in1 | in2);
      OP_SLT:   result_d = {31'h0, $signed(in1) < $signed(in2)};
      OP_SLTU:  result_d = {31'h0, in1 < in2};
      OP_SLL:   result_d = in2 << sh;
      OP_SRL:   result_d = in2 >> sh;
      OP_SRA:   result_d = $signed(in2) >>> sh;
      OP_SLLV:  result_d = in2 << vsh;
      OP_SRLV:  result_d = in2 >> vsh;
      OP_SRAV:  result_d = $signed(in2) >>> vsh;
      OP_ADDI:  result_d = in1 + imm_sx;
      OP_ANDI:  result_d = in1 & imm_zx;
      OP_ORI:   result_d = in1 | imm_zx;
      OP_XORI:  result_d = in1 ^ imm_zx;
      OP_SLTI:  result_d = {31'h0, $signed(in1) < $signed(imm_sx)};
      OP_SLTIU: result_d = {31'h0, in1 < imm_sx};
      OP_LUI:   result_d = {imm, 16'h0000};
      default:  result_d = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result_q <= 32'h0;
    else        result_q <= result_d;
  end

  assign result = result_q;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: expected results are queued when an op is driven and
// popped once the registered result is due, one cycle later.
`timescale 1ns/1ps
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in1, in2;
  logic [15:0] imm;
  logic [4:0]  sh, ALUop;
  logic [31:0] result;

  int n_eval = 0;
  int n_fail = 0;
  logic [31:0] sb[$];

  alu dut (
    .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2),
    .imm(imm), .sh(sh), .ALUop(ALUop), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check_pop(input string tag);
    logic [31:0] exp;
    n_eval++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, result);
    end else begin
      exp = sb.pop_front();
      assert (result === exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, result, exp);
      end
    end
  endtask

  task automatic step(input string tag, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [15:0] i, input logic [4:0] s,
                      input logic [31:0] exp);
    @(negedge clk);
    ALUop = op; in1 = a; in2 = b; imm = i; sh = s;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    check_pop(tag);
  endtask

  initial begin
    // Reset held from time 0 with every input nonzero.
    rst_n = 1'b0;
    in1 = 32'hDEADBEEF; in2 = 32'h12345678; imm = 16'hABCD; sh = 5'd7; ALUop = 5'd3;
    #2;
    sb.push_back(32'h0); check_pop("reset_no_edge");
    @(posedge clk); #1;
    sb.push_back(32'h0); check_pop("reset_with_edge");
    @(negedge clk); rst_n = 1'b1; #1;
    sb.push_back(32'h0); check_pop("reset_release_hold");
    step("post_reset_add", 5'd0, 32'h1, 32'h1, 16'h0, 5'd0, 32'h2);

    // Logic sweep, one op per cycle.
    step("sweep_add",  5'd0, 32'h1, 32'h1, 16'h0, 5'd0, 32'h2);
    step("sweep_sub",  5'd1, 32'h1, 32'h1, 16'h0, 5'd0, 32'h0);
    step("sweep_and",  5'd2, 32'h1, 32'h1, 16'h0, 5'd0, 32'h1);
    step("sweep_or",   5'd3, 32'h1, 32'h1, 16'h0, 5'd0, 32'h1);
    step("sweep_xor",  5'd4, 32'h1, 32'h1, 16'h0, 5'd0, 32'h0);
    step("sweep_nor",  5'd5, 32'h1, 32'h1, 16'h0, 5'd0, 32'hFFFFFFFE);
    step("sweep_slt",  5'd6, 32'h1, 32'h1, 16'h0, 5'd0, 32'h0);
    step("sweep_sltu", 5'd7, 32'h1, 32'h1, 16'h0, 5'd0, 32'h0);
    step("sweep_sll",  5'd8, 32'h1, 32'h1, 16'h0, 5'd0, 32'h1);

    // Signedness and wrap-around.
    step("slt_neg",   5'd6, 32'hFFFFFFFF, 32'h1, 16'h0, 5'd0, 32'h1);
    step("sltu_big",  5'd7, 32'hFFFFFFFF, 32'h1, 16'h0, 5'd0, 32'h0);
    step("sub_neg",   5'd1, 32'hFFFFFFFF, 32'h1, 16'h0, 5'd0, 32'hFFFFFFFE);
    step("add_wrap",  5'd0, 32'hFFFFFFFF, 32'h1, 16'h0, 5'd0, 32'h0);
    step("sub_wrap",  5'd1, 32'h0, 32'h1, 16'h0, 5'd0, 32'hFFFFFFFF);
    step("and_mix",   5'd2, 32'hF0F0F0F0, 32'hFF00FF00, 16'h0, 5'd0, 32'hF000F000);
    step("xor_mix",   5'd4, 32'hF0F0F0F0, 32'hFF00FF00, 16'h0, 5'd0, 32'h0FF00FF0);

    // Shifts.
    step("sll_4",     5'd8,  32'h0, 32'h80000000, 16'h0, 5'd4, 32'h0);
    step("srl_4",     5'd9,  32'h0, 32'h80000000, 16'h0, 5'd4, 32'h08000000);
    step("sra_4",     5'd10, 32'h0, 32'h80000000, 16'h0, 5'd4, 32'hF8000000);
    step("srav_24",   5'd13, 32'h24, 32'h80000000, 16'h0, 5'd0, 32'hF8000000);
    step("sra_pos",   5'd10, 32'h0, 32'h40000000, 16'h0, 5'd31, 32'h0);
    step("sra_0",     5'd10, 32'h0, 32'h80000001, 16'h0, 5'd0, 32'h80000001);
    step("sllv_hi",   5'd11, 32'hFFFFFFE1, 32'h3, 16'h0, 5'd9, 32'h6);
    step("srlv_0",    5'd12, 32'hFFFFFFE0, 32'h80000001, 16'h0, 5'd3, 32'h80000001);
    step("srlv_31",   5'd12, 32'h1F, 32'h80000000, 16'h0, 5'd0, 32'h1);
    step("sll_31",    5'd8,  32'hFFFFFFFF, 32'h3, 16'hFFFF, 5'd31, 32'h80000000);

    // Immediates.
    step("addi",      5'd14, 32'h10, 32'h0, 16'hFFFF, 5'd0, 32'h0000000F);
    step("andi",      5'd15, 32'h10, 32'h0, 16'hFFFF, 5'd0, 32'h00000010);
    step("ori",       5'd16, 32'h10, 32'h0, 16'hFFFF, 5'd0, 32'h0000FFFF);
    step("xori",      5'd17, 32'hFFFF0010, 32'h0, 16'hFFFF, 5'd0, 32'hFFFFFFEF);
    step("slti",      5'd18, 32'h10, 32'h0, 16'hFFFF, 5'd0, 32'h0);
    step("sltiu",     5'd19, 32'h10, 32'h0, 16'hFFFF, 5'd0, 32'h1);
    step("slti_neg",  5'd18, 32'h80000000, 32'h0, 16'h0001, 5'd0, 32'h1);
    step("lui",       5'd20, 32'h12345678, 32'h9ABCDEF0, 16'hFFFF, 5'd0, 32'hFFFF0000);

    // Unused codes clear the result even after a nonzero one.
    step("op21",      5'd21, 32'hDEADBEEF, 32'hCAFEF00D, 16'h5A5A, 5'd13, 32'h0);
    step("lui_again", 5'd20, 32'h0, 32'h0, 16'h1234, 5'd0, 32'h12340000);
    step("op31",      5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF, 5'd31, 32'h0);

    // Reset in the middle of a pending operation discards it.
    step("pre_reset", 5'd0, 32'h3, 32'h4, 16'h0, 5'd0, 32'h7);
    @(negedge clk);
    ALUop = 5'd0; in1 = 32'h100; in2 = 32'h200;
    #2 rst_n = 1'b0; #1;
    sb.push_back(32'h0); check_pop("midop_reset_async");
    @(posedge clk); #1;
    sb.push_back(32'h0); check_pop("midop_reset_hold");
    @(negedge clk); rst_n = 1'b1; #1;
    sb.push_back(32'h0); check_pop("midop_release");
    step("after_reset", 5'd1, 32'h10, 32'h3, 16'h0, 5'd0, 32'h0000000D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 No parameters; datapath width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in1  input  32  operand A (rs).
REQ-005 in2  input  32  operand B (rt).
REQ-006 imm  input  16  immediate field for I-type ops.
REQ-007 sh  input  5  shift amount for constant shifts.
REQ-008 ALUop  input  5  operation select, decoded per REQ-012.
REQ-009 result  output  32  registered operation result.

Function
REQ-010 result SHALL be a register loaded on every rising clk edge with the function of the operands and ALUop sampled at that edge; latency exactly 1 cycle; no enable, no handshake.
REQ-011 All arithmetic SHALL be modulo 2^32; carry-out and overflow are discarded; no flags or exceptions.
REQ-012 ALUop decode (next result):
- 0 ADD: in1 + in2
- 1 SUB: in1 - in2
- 2 AND: in1 & in2
- 3 OR: in1 | in2
- 4 XOR: in1 ^ in2
- 5 NOR: ~(in1 | in2)
- 6 SLT: 1 if signed(in1) < signed(in2), else 0
- 7 SLTU: 1 if unsigned(in1) < unsigned(in2), else 0
- 8 SLL: in2 << sh
- 9 SRL: in2 >> sh, zero fill
- 10 SRA: in2 >> sh, sign fill from in2[31]
- 11 SLLV: in2 << in1[4:0]
- 12 SRLV: in2 >> in1[4:0], zero fill
- 13 SRAV: in2 >> in1[4:0], sign fill
- 14 ADDI: in1 + sign-extended imm
- 15 ANDI: in1 & zero-extended imm
- 16 ORI: in1 | zero-extended imm
- 17 XORI: in1 ^ zero-extended imm
- 18 SLTI: signed compare of in1 against sign-extended imm, result 1/0
- 19 SLTIU: unsigned compare of in1 against sign-extended imm, result 1/0
- 20 LUI: {imm, 16'h0000}
- 21-31: result 0.
REQ-013 Compare ops SHALL drive bits [31:1] to 0.
REQ-014 Shift by 0 SHALL return in2 unchanged; only in1[4:0] SHALL be used for variable shifts, upper bits ignored.
REQ-015 Inputs not used by the selected op SHALL have no effect on result.
REQ-016 Decode SHALL be fully specified for all 32 ALUop codes; no latches; X-free output for known inputs.

Reset
REQ-017 While rst_n is low, result SHALL be 0 immediately (asynchronous), independent of clk.
REQ-018 On rst_n deassertion, result SHALL hold 0 until the first rising clk edge with rst_n high, then follow REQ-010.
REQ-019 Reset asserted mid-operation SHALL discard the pending value; no state beyond result exists.

Verification
REQ-020 Reset: rst_n=0 with all inputs nonzero -> result=0 without a clock edge; release, one edge with in1=1, in2=1, ALUop=0 -> result=2.
REQ-021 Logic sweep with in1=1, in2=1, sh=0, imm=0, one op per cycle -> ops 0..8 give 2, 0, 1, 1, 0, 0xFFFFFFFE, 0, 0, 1, each appearing one cycle after the op is applied.
REQ-022 Signedness: in1=0xFFFFFFFF, in2=1 -> SLT=1, SLTU=0, SUB=0xFFFFFFFE; ADD of 0xFFFFFFFF and 1 -> 0 (wrap).
REQ-023 Shifts: in2=0x80000000, sh=4 -> SLL=0, SRL=0x08000000, SRA=0xF8000000; SRAV with in1=0x24 (in1[4:0]=4) -> 0xF8000000.
REQ-024 Immediates: in1=0x10, imm=0xFFFF -> ADDI=0x0F, ANDI=0x10, ORI=0xFFFF, SLTI=0, SLTIU=1, LUI=0xFFFF0000.
REQ-025 Unused codes: ALUop=21 and ALUop=31 with arbitrary operands -> result=0.
